// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
//   Parallel-to-serial front end for the 1011 sequence-detector path. Accepts
//   WIDTH-bit words over a valid/ready handshake and emits one bit per clock.
//   Back-to-back words stream with no idle cycle: the next word is taken in
//   the final bit cycle of the current one.
//
//   Optional feature macro: SER_PARITY_EN
//     defined   : each word is followed by one even-parity bit (^word)
//     undefined : data bits only; no parity logic is built
//
// Parameters
//   WIDTH      data word width (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] sent first; 0: din[0] sent first
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      synchronous, active-high reset
//   din        parallel word, captured on handshake
//   din_valid  upstream has a word on din
//   din_ready  combinational: block can take a word this cycle
//   ser_bit    serial data/parity bit (registered)
//   ser_valid  ser_bit carries a real bit this cycle (registered)
//   busy       a word is being shifted out (from state register)
// -----------------------------------------------------------------------------
module seq_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             busy
);

`ifdef SER_PARITY_EN
    localparam int unsigned LEN = WIDTH + 1;
`else
    localparam int unsigned LEN = WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   sreg, sreg_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               bit_n;
    logic               valid_n;
    logic               last_c;
    logic               accept_c;
`ifdef SER_PARITY_EN
    logic               par, par_n;
`endif

    // Bit that leaves the word next, depending on shift direction.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its head bit consumed.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Final bit cycle of the current word (parity cycle when enabled).
    assign last_c    = (state == SHIFT) && (cnt == CNT_W'(LEN - 1));
    assign din_ready = !reset && ((state == IDLE) || last_c);
    assign accept_c  = din_valid && din_ready;
    assign busy      = (state == SHIFT);

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        bit_n   = 1'b0;
        valid_n = 1'b0;
`ifdef SER_PARITY_EN
        par_n   = par;
`endif
        if (accept_c) begin
            // First bit goes straight to the output flop; remainder is held.
            state_n = SHIFT;
            cnt_n   = '0;
            bit_n   = head(din);
            sreg_n  = advance(din);
            valid_n = 1'b1;
`ifdef SER_PARITY_EN
            par_n   = ^din;
`endif
        end else if (state == SHIFT) begin
            if (last_c) begin
                state_n = IDLE;
            end else begin
                cnt_n   = cnt + CNT_W'(1);
                valid_n = 1'b1;
`ifdef SER_PARITY_EN
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    bit_n = par;
                end else begin
                    bit_n  = head(sreg);
                    sreg_n = advance(sreg);
                end
`else
                bit_n  = head(sreg);
                sreg_n = advance(sreg);
`endif
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
`ifdef SER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            cnt       <= cnt_n;
            ser_bit   <= bit_n;
            ser_valid <= valid_n;
`ifdef SER_PARITY_EN
            par       <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_serializer
//   Drives an MSB-first and an LSB-first instance with identical stimulus and
//   compares every cycle against a queue model: each accepted word appends its
//   bit sequence to a queue, and one bit leaves the queue per clock.
// -----------------------------------------------------------------------------
module tb_seq_bit_serializer;

    localparam int unsigned WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int unsigned LEN = WIDTH + 1;
`else
    localparam int unsigned LEN = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             m_ready, m_bit, m_valid, m_busy;
    logic             l_ready, l_bit, l_valid, l_busy;

    int errors = 0;
    int checks = 0;

    bit q_msb[$];
    bit q_lsb[$];

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(m_ready), .ser_bit(m_bit), .ser_valid(m_valid), .busy(m_busy)
    );

    seq_bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(l_ready), .ser_bit(l_bit), .ser_valid(l_valid), .busy(l_busy)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // Transmission order of a word: index i is the i-th bit on the wire.
    function automatic logic [LEN-1:0] word_bits(input logic [WIDTH-1:0] w, input bit msb);
        logic [LEN-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++)
            r[i] = msb ? w[WIDTH-1-i] : w[i];
`ifdef SER_PARITY_EN
        r[WIDTH] = ^w;
`endif
        return r;
    endfunction

    // One clock: apply inputs, check ready, clock, advance model, check outputs.
    task automatic step(input logic rst, input logic v, input logic [WIDTH-1:0] d);
        logic           exp_ready;
        logic           acc;
        logic [LEN-1:0] bm, bl;
        reset     = rst;
        din_valid = v;
        din       = d;
        #1;
        // Ready when idle or presenting the final bit of the current word.
        exp_ready = !rst && (q_msb.size() <= 1);
        check("msb_din_ready", m_ready, exp_ready);
        check("lsb_din_ready", l_ready, exp_ready);
        acc = v && exp_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            q_msb.delete();
            q_lsb.delete();
        end else begin
            if (q_msb.size() != 0) void'(q_msb.pop_front());
            if (q_lsb.size() != 0) void'(q_lsb.pop_front());
            if (acc) begin
                bm = word_bits(d, 1'b1);
                bl = word_bits(d, 1'b0);
                for (int i = 0; i < LEN; i++) begin
                    q_msb.push_back(bm[i]);
                    q_lsb.push_back(bl[i]);
                end
            end
        end
        check("msb_ser_valid", m_valid, q_msb.size() != 0);
        check("msb_busy",      m_busy,  q_msb.size() != 0);
        check("msb_ser_bit",   m_bit,   (q_msb.size() != 0) ? q_msb[0] : 1'b0);
        check("lsb_ser_valid", l_valid, q_lsb.size() != 0);
        check("lsb_busy",      l_busy,  q_lsb.size() != 0);
        check("lsb_ser_bit",   l_bit,   (q_lsb.size() != 0) ? q_lsb[0] : 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, WIDTH'($urandom));
    endtask

    initial begin
        reset     = 1'b1;
        din_valid = 1'b0;
        din       = '0;

        // Reset state.
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 8'hFF);

        // Single word 8'hB0 (LSB instance sees 8'hB0 reversed).
        step(1'b0, 1'b1, 8'hB0);
        idle(LEN + 2);

        // Back-to-back: din_valid held high across the word boundary.
        step(1'b0, 1'b1, 8'hB0);
        for (int i = 0; i < LEN; i++)
            step(1'b0, 1'b1, 8'h0B);
        idle(LEN + 2);

        // 8'h0D: LSB-first instance emits 1,0,1,1,0,0,0,0.
        step(1'b0, 1'b1, 8'h0D);
        idle(LEN + 2);

        // Reset in the 3rd bit cycle, then a word on the first free cycle.
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'hA5);
        idle(LEN + 2);

        // Pulsed valid with three idle cycles between words.
        for (int w = 0; w < 4; w++) begin
            step(1'b0, 1'b1, WIDTH'($urandom));
            idle(LEN - 1 + 3);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, WIDTH'($urandom));

        idle(LEN + 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
